// File: rtl/ex_stage_pkg.sv
// Shared opcode and branch-condition encodings for the execute stage and its ALU.
package ex_stage_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SHL   = 3'd5;
  localparam logic [2:0] ALU_SHR   = 3'd6;
  localparam logic [2:0] ALU_PASSB = 3'd7;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_VS = 3'd5;
  localparam logic [2:0] COND_MI = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

endpackage

// File: rtl/ex_stage_alu.sv
// ALU_16: purely combinational WIDTH-bit ALU, wrap-around results, no backpressure.
// z/n follow the result; v reports signed overflow for ADD/SUB only.
module ALU_16
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int SH = $clog2(WIDTH);

  always_comb begin
    alu_out = '0;
    v       = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_out = alu_a + alu_b;
        v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = alu_a - alu_b;
        v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_SHL: alu_out = alu_a << alu_b[SH-1:0];
      ALU_SHR: alu_out = alu_a >> alu_b[SH-1:0];
      default: alu_out = alu_b;
    endcase
  end

  assign z = (alu_out == '0);
  assign n = alu_out[WIDTH-1];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: 1-cycle ALU result into a single-entry EX/MEM register, CCR, branch redirect.
// in_ready drops only while a held result is stalled by out_ready=0 and no redirect is pending.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_wb_en,
  input  logic             in_set_flags,
  input  logic             in_is_branch,
  input  logic [2:0]       in_cond,
  input  logic [WIDTH-1:0] in_br_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RW-1:0]    out_rd,
  output logic             out_wb_en,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target
);

  function automatic logic cond_true(input logic [2:0] cond, input logic z, input logic v,
                                     input logic n);
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_LT: cond_true = n ^ v;
      COND_GE: cond_true = !(n ^ v);
      COND_VS: cond_true = v;
      COND_MI: cond_true = n;
      default: cond_true = 1'b0;
    endcase
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [RW-1:0]    out_rd_q, out_rd_d;
  logic             out_wb_en_q, out_wb_en_d;
  logic [2:0]       ccr_q, ccr_d;
  logic             br_taken_q, br_taken_d;
  logic [WIDTH-1:0] br_target_q, br_target_d;

  logic [WIDTH-1:0] alu_out;
  logic             alu_z, alu_v, alu_n;
  logic             acc, live, load;

  ALU_16 #(.WIDTH(WIDTH)) u_alu (
    .alu_op  (in_alu_op),
    .alu_a   (in_a),
    .alu_b   (in_b),
    .alu_out (alu_out),
    .z       (alu_z),
    .v       (alu_v),
    .n       (alu_n)
  );

  assign in_ready = !out_valid_q || out_ready || br_taken_q;
  assign acc      = in_valid && in_ready;
  // The slot right after a taken branch carries a wrong-path instruction.
  assign live     = acc && !br_taken_q;
  assign load     = live && !in_is_branch;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wb_en_d  = out_wb_en_q;
    ccr_d        = ccr_q;
    br_taken_d   = 1'b0;
    br_target_d  = br_target_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_out;
      out_rd_d     = in_rd;
      out_wb_en_d  = in_wb_en;
      if (in_set_flags) ccr_d = {alu_z, alu_v, alu_n};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (live && in_is_branch && cond_true(in_cond, ccr_q[2], ccr_q[1], ccr_q[0])) begin
      br_taken_d  = 1'b1;
      br_target_d = in_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wb_en_q  <= 1'b0;
      ccr_q        <= '0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wb_en_q  <= out_wb_en_d;
      ccr_q        <= ccr_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_wb_en  = out_wb_en_q;
  assign flag_z     = ccr_q[2];
  assign flag_v     = ccr_q[1];
  assign flag_n     = ccr_q[0];
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed test-plan scenarios followed by randomized traffic against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_alu_op;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_rd;
  logic        in_wb_en, in_set_flags, in_is_branch;
  logic [2:0]  in_cond;
  logic [15:0] in_br_target;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wb_en, flag_z, flag_v, flag_n, br_taken;
  logic [15:0] br_target;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  logic        m_v, m_wb, m_z, m_vf, m_n, m_br;
  logic [15:0] m_res, m_tgt;
  logic [2:0]  m_rd;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(16), .RW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_set_flags(in_set_flags), .in_is_branch(in_is_branch), .in_cond(in_cond),
    .in_br_target(in_br_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .br_taken(br_taken), .br_target(br_target)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU from two's-complement arithmetic on plain integers.
  task automatic ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic z, output logic v, output logic n);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    v  = 1'b0;
    case (op)
      ALU_ADD: begin s = sa + sb; v = (s > 32767) || (s < -32768); r = 16'(s); end
      ALU_SUB: begin s = sa - sb; v = (s > 32767) || (s < -32768); r = 16'(s); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SHL: r = 16'((int'(a) * (1 << (b % 16))) % 65536);
      ALU_SHR: r = 16'(int'(a) / (1 << (b % 16)));
      default: r = b;
    endcase
    z = (r == 16'd0);
    n = (r >= 16'h8000);
  endtask

  function automatic logic ref_cond(input logic [2:0] c, input logic z, input logic v,
                                    input logic n);
    logic lt;
    lt = (n != v);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return lt;
      3'd4: return !lt;
      3'd5: return v;
      3'd6: return n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drv(input logic vld, input logic [2:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [2:0] rd, input logic wb,
                     input logic sf, input logic isb, input logic [2:0] cnd,
                     input logic [15:0] tgt);
    in_valid = vld; in_alu_op = op; in_a = a; in_b = b; in_rd = rd; in_wb_en = wb;
    in_set_flags = sf; in_is_branch = isb; in_cond = cnd; in_br_target = tgt;
  endtask

  // One clock: check in_ready, advance the model, then compare every output.
  task automatic cycle();
    logic rdy, take;
    logic [15:0] r;
    logic z, v, n;
    #1;
    rdy = !m_v || out_ready || m_br;
    chk("in_ready", in_ready, rdy);
    take = in_valid && rdy && !m_br;
    ref_alu(in_alu_op, in_a, in_b, r, z, v, n);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_res = 0; m_rd = 0; m_wb = 0; m_z = 0; m_vf = 0; m_n = 0; m_br = 0; m_tgt = 0;
    end else begin
      logic br_next;
      br_next = take && in_is_branch && ref_cond(in_cond, m_z, m_vf, m_n);
      if (br_next) m_tgt = in_br_target;
      if (take && !in_is_branch) begin
        m_v = 1; m_res = r; m_rd = in_rd; m_wb = in_wb_en;
        if (in_set_flags) begin m_z = z; m_vf = v; m_n = n; end
      end else if (m_v && out_ready) begin
        m_v = 0;
      end
      m_br = br_next;
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_v);
    chk("out_result", out_result, m_res);
    chk("out_rd", out_rd, m_rd);
    chk("out_wb_en", out_wb_en, m_wb);
    chk("ccr", {flag_z, flag_v, flag_n}, {m_z, m_vf, m_n});
    chk("br_taken", br_taken, m_br);
    if (m_br) chk("br_target", br_target, m_tgt);
  endtask

  initial begin
    m_v = 0; m_res = 0; m_rd = 0; m_wb = 0; m_z = 0; m_vf = 0; m_n = 0; m_br = 0; m_tgt = 0;
    rst = 1; out_ready = 1;
    drv(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {flag_z, flag_v, flag_n}, 0);
    chk("rst_br", {br_taken, br_target}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    // SUB 0x8000-1: signed overflow
    drv(1, ALU_SUB, 16'h8000, 16'h0001, 3, 1, 1, 0, 0, 0);
    cycle();
    chk("ovf_result", out_result, 16'h7FFF);
    chk("ovf_rd", out_rd, 3);
    chk("ovf_flags", {flag_z, flag_v, flag_n}, 3'b010);
    chk("ovf_valid", out_valid, 1);

    // SUB 1-1 sets z, EQ branch taken, next slot killed
    drv(1, ALU_SUB, 1, 1, 1, 1, 1, 0, 0, 0);
    cycle();
    drv(1, ALU_ADD, 0, 0, 0, 0, 0, 1, COND_EQ, 16'h0040);
    cycle();
    chk("eq_taken", br_taken, 1);
    chk("eq_target", br_target, 16'h0040);
    drv(1, ALU_ADD, 5, 5, 2, 1, 1, 0, 0, 0);
    cycle();
    chk("kill_br_clear", br_taken, 0);
    chk("kill_no_out", out_valid, 0);
    chk("kill_ccr", {flag_z, flag_v, flag_n}, 3'b100);

    // backpressure on result 2-1
    drv(1, ALU_SUB, 2, 1, 4, 1, 0, 0, 0, 0);
    out_ready = 0;
    cycle();
    drv(1, ALU_ADD, 7, 7, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_result, 16'h0001);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    cycle();
    chk("bp_next_result", out_result, 16'd14);

    // SUB 1-2 without flags, MI not taken
    drv(1, ALU_SUB, 1, 2, 6, 1, 0, 0, 0, 0);
    cycle();
    chk("nf_result", out_result, 16'hFFFF);
    chk("nf_ccr", {flag_z, flag_v, flag_n}, 3'b100);
    drv(1, ALU_ADD, 0, 0, 0, 0, 0, 1, COND_MI, 16'h1234);
    cycle();
    chk("mi_not_taken", br_taken, 0);

    // reset while a result is held and a branch is accepted
    drv(1, ALU_SUB, 0, 1, 7, 1, 1, 0, 0, 0);
    cycle();
    drv(1, ALU_ADD, 0, 0, 0, 0, 0, 1, COND_AL, 16'h0BAD);
    rst = 1;
    cycle();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_br", br_taken, 0);
    chk("mrst_ccr", {flag_z, flag_v, flag_n}, 0);
    rst = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom),
          ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom),
          3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
